// File: rtl/wave_trig_capture.sv
// wave_trig_capture: pre/post-trigger waveform capture into a 2^AW-entry ring buffer.
// Define WAVE_TRIG_AUTO_EN to force a trigger after AUTO_TMO samples spent waiting.
module wave_trig_capture #(
    parameter int          DT_W     = 8,
    parameter int          AW       = 8,
    parameter logic [31:0] AUTO_TMO = 32'd1_000_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DT_W-1:0] sample_in,
    input  logic            sample_vld,
    input  logic            arm,
    input  logic [DT_W-1:0] trig_level,
    input  logic            trig_edge,
    input  logic [AW-1:0]   pre_len,
    input  logic [AW-1:0]   rd_addr,
    output logic [DT_W-1:0] rd_data,
    output logic            busy,
    output logic            done,
    output logic            auto_trig
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic [2:0] {IDLE, PREFILL, WAIT_TRIG, POSTFILL, DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, pre_q, pre_d, trig_ptr_q, trig_ptr_d;
    logic [AW:0]     cnt_q, cnt_d, post_need;
    logic [DT_W-1:0] prev_q, prev_d, rd_data_q;
    logic            prev_vld_q, prev_vld_d, auto_q, auto_d;
    logic            acc, hit, fire, tmo_hit;
    logic [DT_W-1:0] mem [DEPTH];

`ifdef WAVE_TRIG_AUTO_EN
    logic [31:0] tmo_q, tmo_d;
    assign tmo_hit = (tmo_q + 32'd1 == AUTO_TMO);
`else
    assign tmo_hit = 1'b0;
`endif

    assign busy      = state_q inside {PREFILL, WAIT_TRIG, POSTFILL};
    assign done      = state_q == DONE;
    assign auto_trig = auto_q;
    assign rd_data   = rd_data_q;
    assign acc       = busy && sample_vld;
    assign post_need = (AW+1)'(DEPTH) - {1'b0, pre_q};
    assign hit       = prev_vld_q && (trig_edge ? (prev_q >= trig_level && sample_in < trig_level)
                                                : (prev_q < trig_level && sample_in >= trig_level));
    assign fire      = state_q == WAIT_TRIG && acc && (hit || tmo_hit);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        pre_d      = pre_q;
        trig_ptr_d = trig_ptr_q;
        cnt_d      = cnt_q;
        prev_d     = acc ? sample_in : prev_q;
        prev_vld_d = prev_vld_q | acc;
        auto_d     = auto_q;
`ifdef WAVE_TRIG_AUTO_EN
        tmo_d      = (state_q == WAIT_TRIG && acc) ? tmo_q + 32'd1 : tmo_q;
`endif
        if (arm && !busy) begin
            // pre_len is AW bits wide, so it can never exceed DEPTH-1
            state_d    = PREFILL;
            pre_d      = pre_len;
            wr_ptr_d   = '0;
            cnt_d      = '0;
            prev_vld_d = 1'b0;
            auto_d     = 1'b0;
`ifdef WAVE_TRIG_AUTO_EN
            tmo_d      = '0;
`endif
        end else begin
            case (state_q)
                PREFILL: begin
                    if (pre_q == '0) begin
                        state_d = WAIT_TRIG;
                    end else if (acc) begin
                        cnt_d   = (cnt_q + 1'b1 == {1'b0, pre_q}) ? '0 : cnt_q + 1'b1;
                        state_d = (cnt_q + 1'b1 == {1'b0, pre_q}) ? WAIT_TRIG : PREFILL;
                    end
                end
                WAIT_TRIG: begin
                    if (fire) begin
                        trig_ptr_d = wr_ptr_q;
                        cnt_d      = (AW+1)'(1);
                        auto_d     = tmo_hit && !hit;
                        state_d    = (post_need == (AW+1)'(1)) ? DONE : POSTFILL;
                    end
                end
                POSTFILL: begin
                    if (acc) begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = (cnt_q + 1'b1 == post_need) ? DONE : POSTFILL;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            pre_q      <= '0;
            trig_ptr_q <= '0;
            cnt_q      <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            auto_q     <= 1'b0;
            rd_data_q  <= '0;
`ifdef WAVE_TRIG_AUTO_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            pre_q      <= pre_d;
            trig_ptr_q <= trig_ptr_d;
            cnt_q      <= cnt_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            auto_q     <= auto_d;
            rd_data_q  <= mem[trig_ptr_q - pre_q + rd_addr];
`ifdef WAVE_TRIG_AUTO_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    // buffer contents survive reset
    always_ff @(posedge clk) begin
        if (acc) mem[wr_ptr_q] <= sample_in;
    end
endmodule

// File: tb/tb_wave_trig_capture.sv
// tb_wave_trig_capture: table-driven capture scenarios with a read-back scoreboard.
module tb_wave_trig_capture;
    logic       clk = 1'b0, rst;
    logic [7:0] sample_in, trig_level, pre_len, rd_addr, rd_data;
    logic       sample_vld, arm, trig_edge, busy, done, auto_trig;

    int checks = 0, failures = 0;
    int sb[$];
    int idx;

    typedef struct {int scen; int addr; int exp;} vec_t;
    vec_t vecs[$];

    int s_mode[5]  = '{0, 1, 0, 0, 0};
    int s_off[5]   = '{54, 0, 118, 119, 54};
    int s_pre[5]   = '{64, 10, 0, 255, 64};
    int s_edge[5]  = '{0, 1, 0, 0, 0};
    int s_stall[5] = '{0, 0, 0, 0, 1};

    wave_trig_capture #(.DT_W(8), .AW(8), .AUTO_TMO(32'd50)) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_vld(sample_vld), .arm(arm),
        .trig_level(trig_level), .trig_edge(trig_edge), .pre_len(pre_len), .rd_addr(rd_addr),
        .rd_data(rd_data), .busy(busy), .done(done), .auto_trig(auto_trig)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int wave(input int mode, input int off, input int i);
        if (mode == 0) return (i + off) % 256;
        if (mode == 1) return ((i / 10) % 2 == 0) ? 200 : 55;
        return 100;
    endfunction

    task automatic capture(input int mode, input int off, input int pre, input int edg, input int lvl,
                           input int stall, input int budget, output bit got);
        trig_level = 8'(lvl);
        trig_edge  = edg[0];
        pre_len    = 8'(pre);
        sample_vld = 1'b0;
        arm        = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
        idx = 0;
        got = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (stall != 0 && (c == 21 || c == 141)) chk($sformatf("busy_after_ignored_arm_c%0d", c), int'(busy), 1);
            sample_vld = (stall != 0) ? (c % 2 == 0) : 1'b1;
            sample_in  = 8'(wave(mode, off, idx));
            if (sample_vld) idx++;
            arm = (stall != 0 && (c == 20 || c == 140));
            if (arm) pre_len = 8'd10;
            @(posedge clk); #1;
        end
        sample_vld = 1'b0;
        arm        = 1'b0;
    endtask

    task automatic reads(input int scen);
        sample_vld = 1'b0;
        foreach (vecs[i]) begin
            if (vecs[i].scen == scen) begin
                rd_addr = 8'(vecs[i].addr);
                sb.push_back(vecs[i].exp);
                @(posedge clk); #1;
                chk($sformatf("rd_data_s%0d_a%0d", scen, vecs[i].addr), int'(rd_data), sb.pop_front());
            end
        end
    endtask

    initial begin
        bit got;
        vecs.push_back('{0, 64, 128}); vecs.push_back('{0, 63, 127});
        vecs.push_back('{0, 255, 63}); vecs.push_back('{0, 0, 64});
        vecs.push_back('{1, 10, 55});  vecs.push_back('{1, 9, 200});
        vecs.push_back('{1, 0, 200});  vecs.push_back('{1, 19, 55});
        vecs.push_back('{1, 20, 200});
        vecs.push_back('{2, 0, 128});  vecs.push_back('{2, 1, 129});
        vecs.push_back('{2, 255, 127});
        vecs.push_back('{3, 255, 128}); vecs.push_back('{3, 254, 127});
        vecs.push_back('{3, 0, 129});
        vecs.push_back('{4, 64, 128}); vecs.push_back('{4, 63, 127});
        vecs.push_back('{4, 255, 63}); vecs.push_back('{4, 0, 64});
        vecs.push_back('{5, 0, 100});  vecs.push_back('{5, 255, 100});

        rst = 1'b1; sample_in = '0; sample_vld = 1'b0; arm = 1'b0;
        trig_level = '0; trig_edge = 1'b0; pre_len = '0; rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_auto", int'(auto_trig), 0);
        chk("reset_rd_data", int'(rd_data), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int s = 0; s < 5; s++) begin
            capture(s_mode[s], s_off[s], s_pre[s], s_edge[s], 128, s_stall[s], 1000, got);
            chk($sformatf("done_s%0d", s), int'(got), 1);
            chk($sformatf("auto_s%0d", s), int'(auto_trig), 0);
            reads(s);
        end

        capture(2, 0, 4, 0, 128, 0, 600, got);
`ifdef WAVE_TRIG_AUTO_EN
        chk("done_const_auto", int'(got), 1);
        chk("auto_const", int'(auto_trig), 1);
        reads(5);
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
        chk("auto_cleared_by_arm", int'(auto_trig), 0);
`else
        chk("done_const_noauto", int'(got), 0);
        chk("busy_const_noauto", int'(busy), 1);
        chk("auto_const_noauto", int'(auto_trig), 0);
`endif
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("idle_after_rst", int'(busy), 0);

        capture(0, 54, 64, 0, 128, 0, 120, got);
        chk("postfill_not_done", int'(got), 0);
        chk("postfill_busy", int'(busy), 1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_done", int'(done), 0);
        chk("async_rst_auto", int'(auto_trig), 0);
        chk("async_rst_rd_data", int'(rd_data), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        capture(0, 54, 64, 0, 128, 0, 1000, got);
        chk("done_after_rst", int'(got), 1);
        reads(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wave_trig_capture.md
WAVE_TRIG_CAPTURE -- requirements
Module: wave_trig_capture

Interface
REQ-001 SHALL have parameter DT_W, default 8, sample width.
REQ-002 SHALL have parameter AW, default 8, buffer address width; DEPTH = 2^AW.
REQ-003 SHALL have parameter AUTO_TMO, default 32'd1_000_000, auto-trigger timeout in accepted samples.
REQ-004 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port sample_in, input, DT_W, unsigned waveform sample from the upstream square/wave generator.
REQ-007 SHALL have port sample_vld, input, 1, sample_in valid this cycle.
REQ-008 SHALL have port arm, input, 1, single-cycle capture start request.
REQ-009 SHALL have port trig_level, input, DT_W, trigger threshold.
REQ-010 SHALL have port trig_edge, input, 1; 0 = rising, 1 = falling.
REQ-011 SHALL have port pre_len, input, AW, pre-trigger sample count; sampled on arm.
REQ-012 SHALL have port rd_addr, input, AW, logical read index; 0 = oldest captured sample.
REQ-013 SHALL have port rd_data, output, DT_W, buffer data for rd_addr with 1-cycle latency.
REQ-014 SHALL have port busy, output, 1, high in PREFILL, WAIT_TRIG and POSTFILL.
REQ-015 SHALL have port done, output, 1, high in DONE.
REQ-016 SHALL have port auto_trig, output, 1, last capture was forced by timeout.

Function
REQ-017 SHALL implement FSM IDLE -> PREFILL -> WAIT_TRIG -> POSTFILL -> DONE; arm in IDLE or DONE -> PREFILL; arm in busy states ignored.
REQ-018 SHALL, on arm, latch pre_len clamped to DEPTH-1, clear wr_ptr, cnt, prev_valid and auto_trig.
REQ-019 SHALL write sample_in to buffer[wr_ptr] and increment wr_ptr (mod DEPTH) on every sample_vld in PREFILL, WAIT_TRIG and POSTFILL; sample_vld low stalls all counters.
REQ-020 SHALL leave PREFILL after pre_len accepted samples; pre_len = 0 enters WAIT_TRIG directly on the next cycle.
REQ-021 SHALL, in WAIT_TRIG, declare trigger on an accepted sample when prev_valid and (rising: prev < trig_level and cur >= trig_level; falling: prev >= trig_level and cur < trig_level).
REQ-022 SHALL track prev = last accepted sample from arm onward; the first accepted sample after arm is never a trigger.
REQ-023 SHALL, on trigger, record trig_ptr = address written by the triggering sample and enter POSTFILL; the triggering sample counts as the first post sample.
REQ-024 SHALL leave POSTFILL for DONE when DEPTH - pre_len post samples (including the trigger sample) are stored.
REQ-025 SHALL compute start_ptr = trig_ptr - pre_len (mod DEPTH); read physical address = start_ptr + rd_addr (mod DEPTH).
REQ-026 SHALL keep the WAIT_TRIG ring overwriting so that buffer holds the pre_len samples immediately preceding the trigger.
REQ-027 SHALL register rd_data every cycle; content is undefined while busy.
REQ-028 SHALL hold DONE and buffer contents until the next arm.

Reset
REQ-029 SHALL, on rst, force state IDLE, busy = 0, done = 0, auto_trig = 0, rd_data = 0, all pointers/counters 0, independent of clk.
REQ-030 SHALL abort any capture when rst asserts mid-operation; buffer memory is not cleared.

Configuration
REQ-031 SHALL, with macro WAVE_TRIG_AUTO_EN defined, count accepted samples in WAIT_TRIG and force a trigger on the sample that makes the count reach AUTO_TMO, setting auto_trig = 1 until the next arm.
REQ-032 SHALL, without WAVE_TRIG_AUTO_EN, omit the timeout counter, wait in WAIT_TRIG indefinitely, and tie auto_trig to 0.

Verification
REQ-033 Rising trigger: AW=8, pre_len=64, level=128, ramp 0..255 repeating, vld=1 -> done after trigger; rd_addr 64 returns 128, rd_addr 63 returns 127, rd_addr 255 returns 319 mod 256 = 63.
REQ-034 Falling trigger: square wave 200/55 every 10 samples, trig_edge=1, level=128, pre_len=10 -> rd_addr 10 = 55, rd_addr 9 = 200.
REQ-035 pre_len=0 and pre_len=255 (max) -> trigger sample at rd_addr 0 and 255 respectively; total stored = 256.
REQ-036 Stall: sample_vld toggling 1/0 with ramp -> captured data identical to continuous case; arm pulsed while busy -> no restart.
REQ-037 Constant input 100, level 128, WAVE_TRIG_AUTO_EN defined, AUTO_TMO=50 -> auto_trig = 1, done; macro undefined -> stays busy, auto_trig = 0.
REQ-038 rst asserted in POSTFILL -> IDLE, busy = 0, done = 0 asynchronously; new arm completes normally.
